// File: rtl/utxd_pkg.sv
// Shared types and helpers for the UART block transmitter: FSM encoding, header byte slots,
// command codes, baud divider and the serial CRC step.
package utxd_pkg;

  typedef enum logic [2:0] {IDLE, HDR, DAT, CRC, GAP} state_t;

  localparam logic [1:0] HDR_COM  = 2'd0;
  localparam logic [1:0] HDR_LBL  = 2'd1;
  localparam logic [1:0] HDR_ADRH = 2'd2;
  localparam logic [1:0] HDR_ADRL = 2'd3;

  localparam logic [7:0] COM_WR = 8'h00;
  localparam logic [7:0] COM_RD = 8'h80;

  function automatic int calc_div(input int f_clk, input int baud);
    return f_clk / baud;
  endfunction

  // MSB-first LFSR step; feeding the register's own bits back in drives it to zero
  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b,
                                           input logic [15:0] poly);
    logic fb;
    fb = c[15] ^ b;
    return {c[14:0], 1'b0} ^ (fb ? poly : 16'h0000);
  endfunction

  function automatic logic [7:0] bit_rev8(input logic [7:0] d);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = d[7-i];
    return r;
  endfunction

endpackage

// File: rtl/utxd_1byte.sv
// One UART frame (start, 8 data LSB first, stop) at DIV clocks per bit; load is taken on the
// first clock after load&&ready, and ready also rises on the last stop-bit clock for gapless reload.
module utxd_1byte #(
  parameter int DIV = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] dat,
  output logic       txd,
  output logic       ce_bit,
  output logic       last_bit,
  output logic       ready
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;
  logic [3:0]    bit_idx;
  logic [9:0]    sh;
  logic          act;
  logic          bit_end;

  assign bit_end = (cnt == CW'(DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      bit_idx <= '0;
      sh      <= '1;
      act     <= 1'b0;
    end else if (load && ready) begin
      sh      <= {1'b1, dat, 1'b0};
      act     <= 1'b1;
      cnt     <= '0;
      bit_idx <= '0;
    end else if (act) begin
      if (bit_end) begin
        cnt     <= '0;
        sh      <= {1'b1, sh[9:1]};
        bit_idx <= bit_idx + 4'd1;
        if (bit_idx == 4'd9) act <= 1'b0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign txd      = act ? sh[0] : 1'b1;
  assign ce_bit   = act && (cnt == '0) && (bit_idx != 4'd0) && (bit_idx != 4'd9);
  assign last_bit = act && (bit_idx == 4'd9);
  assign ready    = !act || (last_bit && bit_end);

endmodule

// File: rtl/utxd_bl.sv
// UART block transmitter: COM, LBL, ADR hi/lo, LBL RAM bytes (writes only), 2 CRC bytes, idle gap.
// Starts 1 clk after accept, ignores start while busy; UTXD_CRC_INJ_EN adds inj_err to corrupt CRC byte 2.
module utxd_bl
  import utxd_pkg::*;
#(
  parameter int          F_CLK     = 50_000_000,
  parameter int          BAUD      = 115_200,
  parameter logic [15:0] CRC_POLY  = 16'h1021,
  parameter logic [15:0] CRC_INIT  = 16'h0000,
  parameter int          IDLE_BITS = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  com,
  input  logic [7:0]  lbl,
  input  logic [15:0] adr,
`ifdef UTXD_CRC_INJ_EN
  input  logic        inj_err,
`endif
  input  logic [7:0]  rd_dat,
  output logic [15:0] rd_adr,
  output logic        ce_rd,
  output logic        TXD,
  output logic        busy,
  output logic        done
);
  localparam int DIV      = calc_div(F_CLK, BAUD);
  localparam int GAP_CLKS = IDLE_BITS * DIV;
  localparam int GW       = $clog2(GAP_CLKS + 1);

  state_t        state, state_nx;
  logic [8:0]    byte_cnt;
  logic [7:0]    com_q, lbl_q, dat_q, tx_dat;
  logic [15:0]   adr_cnt, crc;
  logic [GW-1:0] gap_cnt;
  logic          crc_on, last_q, ce_rd_d, inj_q, inj_sel;
  logic          tx_load, tx_ready, ce_bit, last_bit;
  logic          dat_en;

`ifdef UTXD_CRC_INJ_EN
  assign inj_sel = inj_err;
`else
  assign inj_sel = 1'b0;
`endif

  assign dat_en = (com_q == COM_WR) && (lbl_q != 8'd0);

  utxd_1byte #(.DIV(DIV)) u_byte (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tx_load),
    .dat      (tx_dat),
    .txd      (TXD),
    .ce_bit   (ce_bit),
    .last_bit (last_bit),
    .ready    (tx_ready)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start) state_nx = HDR;
      HDR:  if (tx_ready && byte_cnt == 9'd3) state_nx = dat_en ? DAT : CRC;
      DAT:  if (tx_ready && byte_cnt == ({1'b0, lbl_q} - 9'd1)) state_nx = CRC;
      CRC:  if (tx_ready && byte_cnt == 9'd2) state_nx = GAP;
      GAP:  if (gap_cnt == '0) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy    = (state != IDLE);
    tx_load = 1'b0;
    tx_dat  = 8'h00;
    case (state)
      HDR: begin
        tx_load = tx_ready;
        case (byte_cnt[1:0])
          HDR_COM:  tx_dat = com_q;
          HDR_LBL:  tx_dat = lbl_q;
          HDR_ADRH: tx_dat = adr_cnt[15:8];
          HDR_ADRL: tx_dat = adr_cnt[7:0];
          default:  tx_dat = 8'h00;
        endcase
      end
      DAT: begin
        tx_load = tx_ready;
        tx_dat  = dat_q;
      end
      CRC: begin
        tx_load = tx_ready && (byte_cnt != 9'd2);
        tx_dat  = (byte_cnt == 9'd0) ? bit_rev8(crc[15:8])
                                     : bit_rev8(crc[7:0]) ^ {8{inj_q}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt <= '0;
      com_q    <= '0;
      lbl_q    <= '0;
      adr_cnt  <= '0;
      crc      <= CRC_INIT;
      dat_q    <= '0;
      gap_cnt  <= '0;
      crc_on   <= 1'b0;
      last_q   <= 1'b0;
      ce_rd    <= 1'b0;
      ce_rd_d  <= 1'b0;
      rd_adr   <= '0;
      inj_q    <= 1'b0;
      done     <= 1'b0;
    end else begin
      ce_rd   <= 1'b0;
      done    <= 1'b0;
      last_q  <= last_bit;
      ce_rd_d <= ce_rd;
      if (state == IDLE && start) begin
        com_q    <= com;
        lbl_q    <= lbl;
        adr_cnt  <= adr;
        crc      <= CRC_INIT;
        byte_cnt <= '0;
        inj_q    <= inj_sel;
      end
      if (tx_load) begin
        byte_cnt <= (state_nx != state) ? 9'd0 : byte_cnt + 9'd1;
        crc_on   <= (state != CRC);
      end
      if (crc_on && ce_bit) crc <= crc_step(crc, TXD, CRC_POLY);
      // Fetch the next data byte at the start of the current stop bit
      if (state == DAT && last_bit && !last_q) begin
        ce_rd   <= 1'b1;
        rd_adr  <= adr_cnt;
        adr_cnt <= adr_cnt + 16'd1;
      end
      if (ce_rd_d) dat_q <= rd_dat;
      if (state == CRC && state_nx == GAP)  gap_cnt <= GW'(GAP_CLKS - 1);
      else if (state == GAP && gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;
      if (state == GAP && gap_cnt == '0) done <= 1'b1;
    end
  end

endmodule

// File: tb/tb_utxd_bl.sv
// Directed bench for utxd_bl: serial receiver model, RAM model, hand-derived header/data expectations.
module tb_utxd_bl;
  localparam int          DIV  = 16;
  localparam logic [15:0] POLY = 16'h1021;
  localparam logic [15:0] INIT = 16'h0000;

  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, inj_err = 1'b0, rx_clr = 1'b0;
  logic [7:0]  com = 8'h00, lbl = 8'h00, rd_dat = 8'h00;
  logic [15:0] adr = 16'h0000, rd_adr;
  logic        ce_rd, txd, busy, done;
  logic [7:0]  ram [0:65535];
  logic [7:0]  rx_q[$];
  logic [15:0] adr_q[$];
  int checks = 0, errors = 0, ferr = 0;
  int done_cnt = 0, busy_cyc = 0, done_busy = 0;
  int rb, ab, db, bb;

  always #5 clk = ~clk;

  utxd_bl #(.F_CLK(1_600_000), .BAUD(100_000), .CRC_POLY(POLY), .CRC_INIT(INIT),
            .IDLE_BITS(12)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .com(com), .lbl(lbl), .adr(adr),
`ifdef UTXD_CRC_INJ_EN
    .inj_err(inj_err),
`endif
    .rd_dat(rd_dat), .rd_adr(rd_adr), .ce_rd(ce_rd), .TXD(txd), .busy(busy), .done(done)
  );

  always @(posedge clk) if (ce_rd) rd_dat <= ram[rd_adr];

  always @(negedge clk) begin
    if (ce_rd) adr_q.push_back(rd_adr);
    if (busy) busy_cyc <= busy_cyc + 1;
    if (done) begin
      done_cnt <= done_cnt + 1;
      if (busy) done_busy <= done_busy + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic rx_frame();
    logic [7:0] b;
    b = 8'h00;
    for (int c = 1; c <= DIV/2 + 9*DIV; c++) begin
      @(negedge clk);
      if (rx_clr) return;
      if (c % DIV == DIV/2) begin
        if (c / DIV == 0 && txd !== 1'b0) ferr++;
        else if (c / DIV >= 1 && c / DIV <= 8) b[c/DIV-1] = txd;
        else if (c / DIV == 9) begin
          if (txd !== 1'b1) ferr++;
          rx_q.push_back(b);
        end
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!rx_clr && txd === 1'b0) rx_frame();
    end
  end

  function automatic logic [15:0] residue(input int from);
    logic [15:0] r;
    logic fb;
    r = INIT;
    for (int i = from; i < rx_q.size(); i++)
      for (int k = 0; k < 8; k++) begin
        fb = r[15] ^ rx_q[i][k];
        r  = {r[14:0], 1'b0} ^ (fb ? POLY : 16'h0000);
      end
    return r;
  endfunction

  task automatic snap();
    rb = rx_q.size(); ab = adr_q.size(); db = done_cnt; bb = busy_cyc;
  endtask

  task automatic pulse_start(input logic [7:0] c, input logic [7:0] l, input logic [15:0] a,
                             input logic inj);
    @(negedge clk);
    com = c; lbl = l; adr = a; inj_err = inj; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string t);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin seen = 1'b1; break; end
    end
    chk({t, "_timeout"}, 32'(seen), 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic verify(input string t, input logic [7:0] c, input logic [7:0] l,
                        input logic [15:0] a, input int nfr, input int nfe);
    int nr;
    logic [15:0] ea;
    nr = rx_q.size() - rb;
    chk({t, "_frames"}, nr, nfr);
    chk({t, "_done"}, done_cnt - db, 1);
    chk({t, "_fetches"}, adr_q.size() - ab, nfe);
    if (nr >= 4) begin
      chk({t, "_com"}, rx_q[rb], c);
      chk({t, "_lbl"}, rx_q[rb+1], l);
      chk({t, "_adrh"}, rx_q[rb+2], a[15:8]);
      chk({t, "_adrl"}, rx_q[rb+3], a[7:0]);
    end
    for (int i = 0; i < nfe && i < nr - 4 && ab + i < adr_q.size(); i++) begin
      ea = a + 16'(i);
      chk($sformatf("%s_rdadr%0d", t, i), adr_q[ab+i], ea);
      chk($sformatf("%s_dat%0d", t, i), rx_q[rb+4+i], ram[ea]);
    end
    chk({t, "_residue"}, residue(rb), 16'h0000);
  endtask

  initial begin
    ram[16'h1234] = 8'hA5; ram[16'h1235] = 8'h5A; ram[16'h1236] = 8'hFF;
    ram[16'hFFFF] = 8'h3C; ram[16'h0000] = 8'hC3;
    #1;
    chk("rst_txd", txd, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ce_rd", ce_rd, 0);
    chk("rst_rd_adr", rd_adr, 16'h0000);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // write block, 3 data bytes, timing of first start bit and whole-block length
    snap();
    pulse_start(8'h00, 8'd3, 16'h1234, 1'b0);
    chk("t1_busy_after_accept", busy, 1);
    chk("t1_txd_before_start", txd, 1);
    @(negedge clk);
    chk("t1_start_bit", txd, 0);
    wait_done("t1");
    verify("t1", 8'h00, 8'd3, 16'h1234, 9, 3);
    chk("t1_busy_cycles", busy_cyc - bb, 1 + 90*DIV + 12*DIV);
    chk("t1_done_busy_low", done_busy, 0);

    // read request: header + CRC only
    snap();
    pulse_start(8'h80, 8'd10, 16'h0040, 1'b0);
    wait_done("t2");
    verify("t2", 8'h80, 8'd10, 16'h0040, 6, 0);

    // address wrap
    snap();
    pulse_start(8'h00, 8'd2, 16'hFFFF, 1'b0);
    wait_done("t3");
    verify("t3", 8'h00, 8'd2, 16'hFFFF, 8, 2);

    // start while busy is ignored
    snap();
    pulse_start(8'h00, 8'd3, 16'h1234, 1'b0);
    repeat (998) @(negedge clk);
    chk("t4_busy_at_1000", busy, 1);
    pulse_start(8'h80, 8'd0, 16'h0000, 1'b0);
    wait_done("t4");
    repeat (400) @(negedge clk);
    verify("t4", 8'h00, 8'd3, 16'h1234, 9, 3);
    chk("t4_idle_after", busy, 0);

    // reset during the start bit of data byte 1, then a clean block
    pulse_start(8'h00, 8'd3, 16'h1234, 1'b0);
    repeat (645) @(negedge clk);
    chk("t5_pre_rst_txd", txd, 0);
    db = done_cnt;
    rx_clr = 1'b1;
    rst_n  = 1'b0;
    #1;
    chk("t5_rst_txd", txd, 1);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_rd_adr", rd_adr, 16'h0000);
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    rx_clr = 1'b0;
    chk("t5_no_done", done_cnt - db, 0);
    snap();
    pulse_start(8'h00, 8'd3, 16'h1234, 1'b0);
    wait_done("t5");
    verify("t5", 8'h00, 8'd3, 16'h1234, 9, 3);

`ifdef UTXD_CRC_INJ_EN
    snap();
    pulse_start(8'h00, 8'd3, 16'h1234, 1'b1);
    wait_done("t6a");
    chk("t6_inj_ok", 32'((rx_q.size() - rb == 9) && (residue(rb) == 16'h0000)), 0);
    snap();
    pulse_start(8'h00, 8'd3, 16'h1234, 1'b0);
    wait_done("t6b");
    chk("t6_clean_ok", 32'((rx_q.size() - rb == 9) && (residue(rb) == 16'h0000)), 1);
`endif

    chk("framing_errors", ferr, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
